// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax result path: vector geometry, index type
// and the streamer state encoding.
package softmax_pkg;

    localparam int SM_N    = 5;
    localparam int SM_W    = 17;
    localparam int SM_IDXW = $clog2(SM_N + 1);

    typedef logic [SM_IDXW-1:0] sm_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sm_state_e;

endpackage

// File: rtl/softmax_argmax_tracker.sv
// Running maximum / index tracker for the streamed quotients (ARGMAX_EN builds).
// The argmax output already includes the element currently on the bus.
module softmax_argmax_tracker
    import softmax_pkg::*;
#(
    parameter int QW   = SM_W - 1,
    parameter int IDXW = SM_IDXW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            beat,
    input  logic [QW-1:0]   data,
    input  logic [IDXW-1:0] idx,
    output logic [IDXW-1:0] argmax
);

    logic [QW-1:0]   max_q;
    logic [IDXW-1:0] max_idx_q;
    logic [QW-1:0]   cand_max;
    logic [IDXW-1:0] cand_idx;

    // Strictly-greater replacement keeps the lowest index on ties.
    always_comb begin
        cand_max = max_q;
        cand_idx = max_idx_q;
        if (idx == IDXW'(1) || data > max_q) begin
            cand_max = data;
            cand_idx = idx;
        end
    end

    assign argmax = cand_idx;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            max_q     <= '0;
            max_idx_q <= '0;
        end else if (beat) begin
            max_q     <= cand_max;
            max_idx_q <= cand_idx;
        end
    end

endmodule

// File: rtl/softmax_result_streamer.sv
// Captures one N-element softmax vector and streams it one element per beat
// with index/last tags. Optional argmax reporting under `ifdef ARGMAX_EN.
module softmax_result_streamer
    import softmax_pkg::*;
#(
    parameter int N    = SM_N,
    parameter int W    = SM_W,
    parameter int IDXW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_vec [1:N],
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-2:0]    out_data,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic            fmt_err,
`ifdef ARGMAX_EN
    output logic [IDXW-1:0] out_argmax,
`endif
    output logic [0:0]      dbg_state
);

    localparam logic [0:0]      ST_IDLE   = IDLE;
    localparam logic [0:0]      ST_SEND   = SEND;
    localparam logic [IDXW-1:0] IDX_FIRST = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(N);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and payload holds while valid && !ready.
    logic [0:0]      state;
    logic [IDXW-1:0] idx;
    logic [W-2:0]    vec_buf [1:N];
    logic            xfer;
    logic            last_beat;
    logic            capture;
    logic            any_fmt_bad;

    assign out_valid = (state == ST_SEND);
    assign last_beat = (idx == IDX_LAST);
    assign xfer      = out_valid && out_ready;
    assign in_ready  = !rst && (!out_valid || (xfer && last_beat));
    assign capture   = in_valid && in_ready;

    assign out_data  = out_valid ? vec_buf[idx] : '0;
    assign out_idx   = out_valid ? idx : '0;
    assign out_last  = out_valid && last_beat;
    assign dbg_state = state;

    always_comb begin
        any_fmt_bad = 1'b0;
        for (int i = 1; i <= N; i++) begin
            any_fmt_bad = any_fmt_bad | ~in_vec[i][W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= IDX_FIRST;
            fmt_err <= 1'b0;
        end else if (capture) begin
            state   <= ST_SEND;
            idx     <= IDX_FIRST;
            fmt_err <= fmt_err | any_fmt_bad;
        end else if (xfer) begin
            if (last_beat) begin
                state <= ST_IDLE;
            end else begin
                idx <= idx + IDXW'(1);
            end
        end
    end

    // Only the quotient is kept; the format marker is consumed by fmt_err at capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 1; i <= N; i++) begin
                vec_buf[i] <= in_vec[i][W-2:0];
            end
        end
    end

`ifdef ARGMAX_EN
    logic [IDXW-1:0] tracker_argmax;

    softmax_argmax_tracker #(
        .QW   (W - 1),
        .IDXW (IDXW)
    ) u_argmax (
        .clk    (clk),
        .rst    (rst),
        .clear  (capture),
        .beat   (xfer),
        .data   (out_data),
        .idx    (idx),
        .argmax (tracker_argmax)
    );

    assign out_argmax = out_last ? tracker_argmax : '0;
`endif

endmodule

// File: tb/tb_softmax_result_streamer.sv
// Scoreboard bench for softmax_result_streamer: randomized vectors, a per-beat
// expected queue filled at capture, and a negedge monitor that checks every cycle.
module tb_softmax_result_streamer;
    import softmax_pkg::*;

    localparam int N    = SM_N;
    localparam int W    = SM_W;
    localparam int IDXW = SM_IDXW;
    localparam int QW   = W - 1;
    localparam int EW   = 1 + IDXW + QW;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_vec [1:N];
    logic            out_valid;
    logic            out_ready;
    logic [QW-1:0]   out_data;
    logic [IDXW-1:0] out_idx;
    logic            out_last;
    logic            fmt_err;
    logic [0:0]      dbg_state;
`ifdef ARGMAX_EN
    logic [IDXW-1:0] out_argmax;
`endif

    softmax_result_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .fmt_err    (fmt_err),
`ifdef ARGMAX_EN
        .out_argmax (out_argmax),
`endif
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]   exp_q [$];
    logic [IDXW-1:0] exp_arg_q [$];
    logic            exp_fmt;
    logic            exp_ready;
    logic [EW-1:0]   front;
    int              checks;
    int              failures;
    int              ready_mode;
    int              pat_i;
    logic [3:0]      pat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: every element becomes one beat; argmax is the first maximum.
    task automatic push_vector();
        int best;
        best = 1;
        for (int i = 1; i <= N; i++) begin
            exp_q.push_back({(i == N), IDXW'(i), in_vec[i][QW-1:0]});
            if (in_vec[i][W-1] == 1'b0) exp_fmt = 1'b1;
            if (in_vec[i][QW-1:0] > in_vec[best][QW-1:0]) best = i;
        end
        exp_arg_q.push_back(IDXW'(best));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready_during_rst", {31'b0, in_ready}, 32'd0);
            exp_q.delete();
            exp_arg_q.delete();
            exp_fmt = 1'b0;
        end else begin
            exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
            check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
            check("dbg_state", {31'b0, dbg_state}, {31'b0, exp_q.size() != 0});
            check("fmt_err", {31'b0, fmt_err}, {31'b0, exp_fmt});
            if (exp_q.size() != 0) begin
                front = exp_q[0];
                check("out_data", {16'b0, out_data}, {16'b0, front[QW-1:0]});
                check("out_idx", {29'b0, out_idx}, {29'b0, front[QW+IDXW-1:QW]});
                check("out_last", {31'b0, out_last}, {31'b0, front[EW-1]});
`ifdef ARGMAX_EN
                check("out_argmax", {29'b0, out_argmax},
                      front[EW-1] ? {29'b0, exp_arg_q[0]} : 32'd0);
`endif
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    if (front[EW-1]) void'(exp_arg_q.pop_front());
                end
            end else begin
                check("idle_out_data", {16'b0, out_data}, 32'd0);
                check("idle_out_idx", {29'b0, out_idx}, 32'd0);
                check("idle_out_last", {31'b0, out_last}, 32'd0);
            end
            if (in_valid && in_ready) push_vector();
        end
    end

    // ---------------- consumer ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                out_ready = pat[pat_i];
                pat_i = (pat_i + 1) % 4;
            end
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input logic [W-1:0] a, b, c, d, e);
        in_vec[1] = a;
        in_vec[2] = b;
        in_vec[3] = c;
        in_vec[4] = d;
        in_vec[5] = e;
    endtask

    task automatic rand_vec(input int err_pct);
        for (int i = 1; i <= N; i++) begin
            in_vec[i][W-1] = ($urandom_range(0, 99) < err_pct) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 1) == 1)
                in_vec[i][QW-1:0] = QW'($urandom_range(0, 3));
            else
                in_vec[i][QW-1:0] = QW'($urandom_range(0, 65535));
        end
    endtask

    task automatic send_vec();
        logic hit;
        hit = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                hit = 1'b1;
                break;
            end
        end
        check("send_accept", {31'b0, hit}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        check("drain", {31'b0, done}, 32'd1);
        tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        checks     = 0;
        failures   = 0;
        exp_fmt    = 1'b0;
        ready_mode = 0;
        pat_i      = 0;
        pat        = 4'b1001;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        set_vec('0, '0, '0, '0, '0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // basic vector, consumer always ready
        set_vec(17'h1_8000, 17'h1_4000, 17'h1_2000, 17'h1_1000, 17'h1_0800);
        send_vec();
        wait_drain();

        // backpressure 1,0,0,1 with a second vector waiting
        ready_mode = 2;
        rand_vec(0);
        send_vec();
        rand_vec(0);
        send_vec();
        wait_drain();

        // back-to-back: second vector held from beat 3 of the first
        ready_mode = 0;
        rand_vec(0);
        send_vec();
        rand_vec(0);
        tick();
        tick();
        send_vec();
        wait_drain();

        // random traffic, clean format
        ready_mode = 1;
        for (int v = 0; v < 20; v++) begin
            rand_vec(0);
            repeat ($urandom_range(0, 2)) tick();
            send_vec();
        end
        wait_drain();

        // format error, then a clean vector; fmt_err must stay set
        ready_mode = 0;
        set_vec(17'h1_8000, 17'h1_4000, 17'h0_1234, 17'h1_1000, 17'h1_0800);
        send_vec();
        rand_vec(0);
        send_vec();
        wait_drain();

        // argmax tie resolves to the lower index
        set_vec(17'h1_0100, 17'h1_0400, 17'h1_0200, 17'h1_0400, 17'h1_0000);
        send_vec();
        wait_drain();

        // reset during beat 2, then a fresh vector
        rand_vec(0);
        send_vec();
        tick();
        pulse_reset();
        rand_vec(0);
        send_vec();
        wait_drain();

        // random traffic with occasional format errors
        ready_mode = 1;
        for (int v = 0; v < 15; v++) begin
            rand_vec(10);
            repeat ($urandom_range(0, 2)) tick();
            send_vec();
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/softmax_result_streamer.md
# softmax_result_streamer

Output-side streamer for the softmax datapath. It captures one parallel vector of N 17-bit softmax results on a valid/ready handshake and transmits the elements one per beat, with index and last tags, to a serial consumer such as the AXI-style writeback. It sits directly after the combinational softmax core and is the transmit end of the softmax result interface. It also checks the constant leading format bit and, optionally, reports the argmax of each vector.

## Interface
- N, 5, number of elements per vector (≥2)
- W, 17, element width; bit W-1 is the format marker (always 1 from the core), bits W-2:0 are the quotient
- IDXW, $clog2(N+1), index width (3 for N=5)

- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  vector valid
- in_ready  output  1  streamer can accept a vector this cycle
- in_vec  input  [W-1:0] x [1:N]  softmax vector, 1-based like the core outputs
- out_valid  output  1  element beat valid
- out_ready  input  1  consumer accepts beat
- out_data  output  W-1  element quotient (bits W-2:0 of in_vec[idx])
- out_idx  output  IDXW  element index, 1..N
- out_last  output  1  high on the beat with out_idx==N
- fmt_err  output  1  sticky; set if any captured element has bit W-1 == 0
- out_argmax  output  IDXW  (ARGMAX_EN only) index of the largest quotient, valid on the last beat

## Operation
- States: IDLE, SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid captures in_vec into an N×W buffer, sets idx=1, and moves to SEND.
- SEND:
  - out_valid=1; out_data=buf[idx][W-2:0]; out_idx=idx; out_last=(idx==N).
  - A beat transfers when out_valid && out_ready. On transfer with idx<N: idx+1.
- Last-beat transfer:
  - in_ready=1 combinationally in that cycle.
  - If in_valid is also high, the new vector is captured, idx=1, and the state stays SEND (zero bubble).
  - Otherwise the state goes to IDLE.
- in_ready is 0 in SEND except on the last-beat transfer.
- While out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
- fmt_err:
  - Evaluated at capture: OR of ~in_vec[i][W-1] over all i.
  - Sticky until rst. The data is still streamed unmodified.
- Buffer contents are undefined after reset. They are never driven out before the first capture.

## Timing
- Reset values: state IDLE, idx=1, out_valid=0, out_last=0, out_data=0, out_idx=0 when out_valid=0, fmt_err=0, out_argmax=0.
- in_ready=0 while rst is high.
- Reset mid-vector: the remaining beats are dropped, and on the cycle after rst falls the block is in IDLE with in_ready=1.
- Vector accepted at edge t gives first out_valid=1 after edge t (cycle t+1).
- With out_ready held high, beats occur at t+1..t+N. A vector presented during beat N is accepted that cycle, and its beat 1 follows at t+N+1.
- Throughput is one element per cycle, N cycles per vector.
- out_* are registered or derived only from registered state; there is no combinational path from in_vec to out_data.

## Configuration
- ARGMAX_EN defined:
  - A running max register (W-1 bits) and index register are updated on every transferred beat.
  - out_argmax on the last beat = index of the maximum over elements 1..N, including the current element compared combinationally.
  - Ties resolve to the lowest index.
  - The running registers reset when a new vector is captured.
  - out_argmax is 0 when out_last=0.
- ARGMAX_EN undefined: the port, registers and comparator are absent. All other behaviour is identical.

## Structure
- Shared package softmax_pkg holds:
  - localparams SM_N=5 and SM_W=17;
  - the index type;
  - the state enum typedef {IDLE, SEND}.
- One sub-module, softmax_argmax_tracker (running compare/index), is instantiated only under ARGMAX_EN.
- The buffer, counter and FSM stay in the top.

## Test plan
- Basic vector, out_ready=1:
  - Stimulus: vector {17'h1_8000, 1_4000, 1_2000, 1_1000, 1_0800}.
  - Response: beats 8000, 4000, 2000, 1000, 0800 with idx 1..5 on cycles t+1..t+5, out_last only on idx 5, fmt_err=0, argmax=1.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1.
  - Response: data/idx stable during stalls, no beat lost or duplicated, in_ready=0 until the last beat transfers.
- Back-to-back:
  - Stimulus: second vector held valid from beat 3 of the first.
  - Response: accepted exactly on the first vector's beat-5 transfer, its idx 1 on the next cycle, no idle cycle.
- Format error:
  - Stimulus: element 3 = 17'h0_1234.
  - Response: fmt_err=1 after capture, data 1234 still streamed, fmt_err stays high through a following clean vector until rst.
- Argmax tie (ARGMAX_EN):
  - Stimulus: quotients {0100, 0400, 0200, 0400, 0000}.
  - Response: out_argmax=2 on the last beat.
- Reset mid-stream:
  - Stimulus: rst high during beat 2 for one cycle.
  - Response: out_valid=0 the next cycle, in_ready=1, fmt_err=0, and a new vector streams from idx 1.
